// File: rtl/simple_stream_pkg.sv
// Shared types and constants for the simple traffic generator / stream checker pair.
package simple_stream_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned IDX_W      = 8;
    localparam int unsigned CODE_W     = 3;
    localparam int unsigned GOOD_CNT_W = 32;
    localparam int unsigned LFSR_W     = 16;

    localparam logic [LFSR_W-1:0] LFSR_SEED           = 16'hACE1;
    localparam logic [DATA_W-1:0] DEFAULT_HEADER        = 32'h01000360;
    localparam int unsigned       DEFAULT_PAYLOAD_WORDS = 216;

    typedef enum logic [CODE_W-1:0] {
        ERR_NONE         = 3'd0,
        ERR_HEADER       = 3'd1,
        ERR_DATA         = 3'd2,
        ERR_EARLY_LAST   = 3'd3,
        ERR_MISSING_LAST = 3'd4
    } err_code_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // One accepted stream beat.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } axis_beat_t;

    // Outcome of checking one accepted beat, applied to the status one cycle later.
    typedef struct packed {
        logic      err;
        err_code_t code;
        logic      good;
    } beat_event_t;

    // Expected payload value for 1-based payload index.
    function automatic logic [DATA_W-1:0] payload_word(input logic [IDX_W-1:0] idx);
        return DATA_W'(idx);
    endfunction

endpackage

// File: rtl/simple_stream_checker_ready_lfsr.sv
// Pseudo-random ready generator: 16-bit Fibonacci LFSR (taps 16,14,13,11),
// ready is low when the two low LFSR bits are both set (about 25% of cycles).
// Only instantiated when SIMPLE_STREAM_CHECKER_BACKPRESSURE_EN is defined.
module ready_lfsr
    import simple_stream_pkg::*;
(
    input  logic clk,
    input  logic reset,
    output logic ready_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic              ready_q;

    // Right-shifting Fibonacci step; feedback bit enters at the top.
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[LFSR_W-1:1]};
    end

    // LFSR advances every cycle; ready is a registered decode of its low bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q  <= LFSR_SEED;
            ready_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            ready_q <= ~(lfsr_q[1] & lfsr_q[0]);
        end
    end

    assign ready_o = ready_q;

endmodule

// File: rtl/simple_stream_checker.sv
// AXI-Stream sink that checks generator packets (header, payload ramp, TLAST
// placement) and keeps good-packet / error counters and sticky status.
// Optional macro: SIMPLE_STREAM_CHECKER_BACKPRESSURE_EN adds LFSR-driven TREADY stalls.
module simple_stream_checker
    import simple_stream_pkg::*;
#(
    parameter logic [DATA_W-1:0] EXPECTED_HEADER = DEFAULT_HEADER,
    parameter int unsigned       PAYLOAD_WORDS   = DEFAULT_PAYLOAD_WORDS,
    parameter int unsigned       ERR_CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     s_TDATA,
    input  logic                  s_TVALID,
    input  logic                  s_TLAST,
    output logic                  s_TREADY,
    output logic [GOOD_CNT_W-1:0] pkt_good_count,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic                  err_sticky,
    output logic [CODE_W-1:0]     first_err_code,
    output logic                  in_packet
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_WORDS);

    logic        tready;
    logic        accept_c;
    axis_beat_t  beat_c;
    logic        mismatch_c;
    logic        last_idx_c;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pkt_err_q, pkt_err_d;
    beat_event_t      ev_q, ev_d;

    logic [GOOD_CNT_W-1:0] pkt_good_count_q;
    logic [ERR_CNT_W-1:0]  err_count_q;
    logic                  err_sticky_q;
    err_code_t             first_err_code_q;
    logic                  in_packet_q;

`ifdef SIMPLE_STREAM_CHECKER_BACKPRESSURE_EN
    ready_lfsr u_ready_lfsr (
        .clk     (clk),
        .reset   (reset),
        .ready_o (tready)
    );
`else
    logic tready_q;

    // Ready is low only in reset and held high afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            tready_q <= 1'b0;
        end else begin
            tready_q <= 1'b1;
        end
    end

    assign tready = tready_q;
`endif

    assign s_TREADY   = tready;
    assign accept_c   = s_TVALID & tready;
    assign beat_c     = {s_TLAST, s_TDATA};
    assign mismatch_c = (beat_c.data != payload_word(idx_q));
    assign last_idx_c = (idx_q == LAST_IDX);

    // Packet state, payload index and per-packet error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pkt_err_q <= 1'b0;
            ev_q      <= '{err: 1'b0, code: ERR_NONE, good: 1'b0};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pkt_err_q <= pkt_err_d;
            ev_q      <= ev_d;
        end
    end

    // Next-state and per-beat check; at most one error event per beat, with
    // TLAST placement errors taking precedence over a data mismatch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pkt_err_d = pkt_err_q;
        ev_d      = '{err: 1'b0, code: ERR_NONE, good: 1'b0};

        if (accept_c) begin
            unique case (state_q)
                IDLE: begin
                    pkt_err_d = 1'b0;
                    if (beat_c.data != EXPECTED_HEADER) begin
                        ev_d.err  = 1'b1;
                        ev_d.code = ERR_HEADER;
                        if (!beat_c.last) begin
                            state_d = DRAIN;
                        end
                    end else if (beat_c.last) begin
                        ev_d.err  = 1'b1;
                        ev_d.code = ERR_EARLY_LAST;
                    end else begin
                        state_d = PAYLOAD;
                        idx_d   = IDX_W'(1);
                    end
                end

                PAYLOAD: begin
                    if (beat_c.last && !last_idx_c) begin
                        ev_d.err  = 1'b1;
                        ev_d.code = ERR_EARLY_LAST;
                        state_d   = IDLE;
                        idx_d     = '0;
                    end else if (last_idx_c && !beat_c.last) begin
                        ev_d.err  = 1'b1;
                        ev_d.code = ERR_MISSING_LAST;
                        state_d   = DRAIN;
                        idx_d     = '0;
                    end else if (last_idx_c) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        if (mismatch_c) begin
                            ev_d.err  = 1'b1;
                            ev_d.code = ERR_DATA;
                        end else if (!pkt_err_q) begin
                            ev_d.good = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        if (mismatch_c) begin
                            ev_d.err  = 1'b1;
                            ev_d.code = ERR_DATA;
                        end
                    end
                    if (ev_d.err) begin
                        pkt_err_d = 1'b1;
                    end
                end

                DRAIN: begin
                    if (beat_c.last) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Status registers, updated one cycle after the beat that caused the event.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_good_count_q <= '0;
            err_count_q      <= '0;
            err_sticky_q     <= 1'b0;
            first_err_code_q <= ERR_NONE;
            in_packet_q      <= 1'b0;
        end else begin
            in_packet_q <= (state_q != IDLE);
            if (ev_q.good) begin
                pkt_good_count_q <= pkt_good_count_q + GOOD_CNT_W'(1);
            end
            if (ev_q.err) begin
                if (err_count_q != '1) begin
                    err_count_q <= err_count_q + ERR_CNT_W'(1);
                end
                if (!err_sticky_q) begin
                    err_sticky_q     <= 1'b1;
                    first_err_code_q <= ev_q.code;
                end
            end
        end
    end

    assign pkt_good_count = pkt_good_count_q;
    assign err_count      = err_count_q;
    assign err_sticky     = err_sticky_q;
    assign first_err_code = first_err_code_q;
    assign in_packet      = in_packet_q;

endmodule
